// File: rtl/id_ex_stage_if.sv
// Bus between decode, the ID/EX stage, the forwarding sources and the ALU.
// The master side drives decode, MEM/WB forwarding and pipeline control;
// the slave side (the stage) returns the stall request and the EX outputs.
interface id_ex_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) ();
    logic                  id_valid;
    logic [3:0]            id_alu_op;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [DATA_W-1:0]     id_rs_val;
    logic [DATA_W-1:0]     id_rt_val;
    logic [DATA_W-1:0]     id_imm;
    logic                  id_use_imm;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  exm_reg_write;
    logic [REG_ADDR_W-1:0] exm_rd;
    logic [DATA_W-1:0]     exm_result;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_data;
    logic                  flush;
    logic                  mem_stall;
    logic                  id_stall;
    logic                  ex_valid;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic [3:0]            ex_alu_op;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0]     ex_arg1;
    logic [DATA_W-1:0]     ex_arg2;
    logic [DATA_W-1:0]     ex_store_data;

    modport master (
        output id_valid, id_alu_op, id_rs, id_rt, id_rd, id_rs_val, id_rt_val,
               id_imm, id_use_imm, id_reg_write, id_mem_read, id_mem_write,
               exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_data,
               flush, mem_stall,
        input  id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_alu_op, ex_rd, ex_arg1, ex_arg2, ex_store_data
    );

    modport slave (
        input  id_valid, id_alu_op, id_rs, id_rt, id_rd, id_rs_val, id_rt_val,
               id_imm, id_use_imm, id_reg_write, id_mem_read, id_mem_write,
               exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_data,
               flush, mem_stall,
        output id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_alu_op, ex_rd, ex_arg1, ex_arg2, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the MIPS core. Captures the decoded instruction
// (with writeback bypass on the register-file read data), forwards MEM/WB
// results into the ALU operands, and inserts a bubble on load-use hazards.
module id_ex_stage #(
    parameter int         DATA_W      = 32,
    parameter int         REG_ADDR_W  = 5,
    // Encoding of ALUOP_ADD_U from defs.v; used as the harmless bubble op.
    parameter logic [3:0] ALUOP_ADD_U = 4'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = {REG_ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0]     ZERO_DAT = {DATA_W{1'b0}};

    typedef struct packed {
        logic                  valid;
        logic [3:0]            op;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     rs_val;
        logic [DATA_W-1:0]     rt_val;
        logic [DATA_W-1:0]     imm;
        logic                  use_imm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } ex_t;

    ex_t  r_ex;
    ex_t  w_ex_nxt;
    ex_t  w_capture;
    logic w_hazard;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // Empty slot. Source indices are cleared too so a bubble never forwards.
    function automatic ex_t f_bubble();
        ex_t b;
        b.valid     = 1'b0;
        b.op        = ALUOP_ADD_U;
        b.rs        = ZERO_REG;
        b.rt        = ZERO_REG;
        b.rd        = ZERO_REG;
        b.rs_val    = ZERO_DAT;
        b.rt_val    = ZERO_DAT;
        b.imm       = ZERO_DAT;
        b.use_imm   = 1'b0;
        b.reg_write = 1'b0;
        b.mem_read  = 1'b0;
        b.mem_write = 1'b0;
        return b;
    endfunction

    // Operand forwarding: r0 is hard-wired, MEM wins over WB.
    function automatic logic [DATA_W-1:0] f_fwd(
        input logic [REG_ADDR_W-1:0] r,
        input logic [DATA_W-1:0]     stored,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic [DATA_W-1:0]     m_res,
        input logic                  w_we,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic [DATA_W-1:0]     w_dat
    );
        logic [DATA_W-1:0] v;
        if (r == ZERO_REG) begin
            v = stored;
        end else if (m_we && (m_rd == r)) begin
            v = m_res;
        end else if (w_we && (w_rd == r)) begin
            v = w_dat;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Load in EX whose destination is read by the instruction in decode.
    assign w_hazard = r_ex.valid & r_ex.mem_read & (r_ex.rd != ZERO_REG) &
                      bus.id_valid &
                      ((r_ex.rd == bus.id_rs) |
                       ((r_ex.rd == bus.id_rt) & ~bus.id_use_imm));

    // Build the decode capture (with WB bypass) and pick the next EX contents.
    always_comb begin
        w_capture           = f_bubble();
        w_capture.valid     = 1'b1;
        w_capture.op        = bus.id_alu_op;
        w_capture.rs        = bus.id_rs;
        w_capture.rt        = bus.id_rt;
        w_capture.rd        = bus.id_rd;
        w_capture.imm       = bus.id_imm;
        w_capture.use_imm   = bus.id_use_imm;
        w_capture.reg_write = bus.id_reg_write;
        w_capture.mem_read  = bus.id_mem_read;
        w_capture.mem_write = bus.id_mem_write;
        if (bus.wb_reg_write && (bus.wb_rd != ZERO_REG) && (bus.wb_rd == bus.id_rs)) begin
            w_capture.rs_val = bus.wb_data;
        end else begin
            w_capture.rs_val = bus.id_rs_val;
        end
        if (bus.wb_reg_write && (bus.wb_rd != ZERO_REG) && (bus.wb_rd == bus.id_rt)) begin
            w_capture.rt_val = bus.wb_data;
        end else begin
            w_capture.rt_val = bus.id_rt_val;
        end

        if (bus.mem_stall) begin
            w_ex_nxt = r_ex;
        end else if (bus.flush || w_hazard || !bus.id_valid) begin
            w_ex_nxt = f_bubble();
        end else begin
            w_ex_nxt = w_capture;
        end
    end

    // EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= f_bubble();
        end else begin
            r_ex <= w_ex_nxt;
        end
    end

    assign w_fwd_rs = f_fwd(r_ex.rs, r_ex.rs_val, bus.exm_reg_write, bus.exm_rd,
                            bus.exm_result, bus.wb_reg_write, bus.wb_rd, bus.wb_data);
    assign w_fwd_rt = f_fwd(r_ex.rt, r_ex.rt_val, bus.exm_reg_write, bus.exm_rd,
                            bus.exm_result, bus.wb_reg_write, bus.wb_rd, bus.wb_data);

    assign bus.id_stall      = bus.mem_stall | (w_hazard & ~bus.flush);
    assign bus.ex_valid      = r_ex.valid;
    assign bus.ex_reg_write  = r_ex.reg_write;
    assign bus.ex_mem_read   = r_ex.mem_read;
    assign bus.ex_mem_write  = r_ex.mem_write;
    assign bus.ex_alu_op     = r_ex.op;
    assign bus.ex_rd         = r_ex.rd;
    assign bus.ex_arg1       = w_fwd_rs;
    assign bus.ex_arg2       = r_ex.use_imm ? r_ex.imm : w_fwd_rt;
    assign bus.ex_store_data = w_fwd_rt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a slot-level reference model.
module tb_id_ex_stage;
    localparam int         DW    = 32;
    localparam int         AW    = 5;
    localparam logic [3:0] ADD_U = 4'h0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

    id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .ALUOP_ADD_U(ADD_U)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference model: the instruction currently sitting in EX.
    typedef struct {
        logic          valid;
        logic [3:0]    op;
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] rs_val, rt_val, imm;
        logic          use_imm, rw, mr, mw;
    } slot_t;

    slot_t m;
    logic  args_known;   // operand values defined (valid instr or post-reset)

    function automatic slot_t mk_bubble();
        slot_t b;
        b.valid = 1'b0; b.op = ADD_U; b.rs = '0; b.rt = '0; b.rd = '0;
        b.rs_val = '0; b.rt_val = '0; b.imm = '0;
        b.use_imm = 1'b0; b.rw = 1'b0; b.mr = 1'b0; b.mw = 1'b0;
        return b;
    endfunction

    function automatic logic [DW-1:0] regval(input logic [AW-1:0] r, input logic [DW-1:0] rf);
        if (bus.wb_reg_write && r != 0 && bus.wb_rd == r) return bus.wb_data;
        return rf;
    endfunction

    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] r, input logic [DW-1:0] stored);
        if (r == 0) return stored;
        if (bus.exm_reg_write && bus.exm_rd == r) return bus.exm_result;
        if (bus.wb_reg_write && bus.wb_rd == r) return bus.wb_data;
        return stored;
    endfunction

    function automatic logic m_hazard();
        return m.valid && m.mr && (m.rd != 0) && bus.id_valid &&
               ((m.rd == bus.id_rs) || ((m.rd == bus.id_rt) && !bus.id_use_imm));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] f1, f2;
        chk("id_stall", 32'(bus.id_stall), 32'(bus.mem_stall | (m_hazard() & ~bus.flush)));
        chk("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
        chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.rw));
        chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.mr));
        chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(m.mw));
        chk("ex_alu_op", 32'(bus.ex_alu_op), 32'(m.op));
        chk("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
        if (args_known) begin
            f1 = fwd(m.rs, m.rs_val);
            f2 = fwd(m.rt, m.rt_val);
            chk("ex_arg1", bus.ex_arg1, f1);
            chk("ex_arg2", bus.ex_arg2, m.use_imm ? m.imm : f2);
            chk("ex_store_data", bus.ex_store_data, f2);
        end
    endtask

    // Check at the falling edge, then advance the model over one rising edge.
    task automatic cycle();
        slot_t nx;
        logic  kn;
        @(negedge clk);
        check_all();
        nx = m;
        kn = args_known;
        if (!rst_n) begin
            nx = mk_bubble(); kn = 1'b1;
        end else if (bus.mem_stall) begin
            kn = args_known;
        end else if (bus.flush || m_hazard() || !bus.id_valid) begin
            nx = mk_bubble(); kn = 1'b0;
        end else begin
            nx.valid = 1'b1; nx.op = bus.id_alu_op;
            nx.rs = bus.id_rs; nx.rt = bus.id_rt; nx.rd = bus.id_rd;
            nx.rs_val = regval(bus.id_rs, bus.id_rs_val);
            nx.rt_val = regval(bus.id_rt, bus.id_rt_val);
            nx.imm = bus.id_imm; nx.use_imm = bus.id_use_imm;
            nx.rw = bus.id_reg_write; nx.mr = bus.id_mem_read; nx.mw = bus.id_mem_write;
            kn = 1'b1;
        end
        @(posedge clk);
        m = nx;
        args_known = kn;
        #1;
    endtask

    task automatic idle();
        bus.id_valid = 1'b0; bus.id_alu_op = 4'h0; bus.id_rs = '0; bus.id_rt = '0;
        bus.id_rd = '0; bus.id_rs_val = '0; bus.id_rt_val = '0; bus.id_imm = '0;
        bus.id_use_imm = 1'b0; bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0;
        bus.id_mem_write = 1'b0; bus.exm_reg_write = 1'b0; bus.exm_rd = '0;
        bus.exm_result = '0; bus.wb_reg_write = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        bus.flush = 1'b0; bus.mem_stall = 1'b0;
    endtask

    task automatic id_instr(input logic [3:0] op, input logic [AW-1:0] rs, rt, rd,
                            input logic [DW-1:0] rsv, rtv, input logic mr);
        bus.id_valid = 1'b1; bus.id_alu_op = op; bus.id_rs = rs; bus.id_rt = rt;
        bus.id_rd = rd; bus.id_rs_val = rsv; bus.id_rt_val = rtv; bus.id_imm = 32'h0000_0044;
        bus.id_use_imm = mr; bus.id_reg_write = 1'b1; bus.id_mem_read = mr; bus.id_mem_write = 1'b0;
    endtask

    task automatic rand_inputs();
        bus.id_valid = ($urandom_range(0, 3) != 0);
        bus.id_alu_op = 4'($urandom);
        bus.id_rs = AW'($urandom_range(0, 7)); bus.id_rt = AW'($urandom_range(0, 7));
        bus.id_rd = AW'($urandom_range(0, 7));
        bus.id_rs_val = $urandom; bus.id_rt_val = $urandom; bus.id_imm = $urandom;
        bus.id_use_imm = 1'($urandom); bus.id_reg_write = 1'($urandom);
        bus.id_mem_read = ($urandom_range(0, 2) == 0); bus.id_mem_write = 1'($urandom);
        bus.exm_reg_write = 1'($urandom); bus.exm_rd = AW'($urandom_range(0, 7));
        bus.exm_result = $urandom;
        bus.wb_reg_write = 1'($urandom); bus.wb_rd = AW'($urandom_range(0, 7));
        bus.wb_data = $urandom;
        bus.flush = ($urandom_range(0, 9) == 0);
        bus.mem_stall = ($urandom_range(0, 6) == 0);
    endtask

    initial begin
        idle();
        m = mk_bubble();
        args_known = 1'b1;
        #1;
        check_all();
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Back-to-back dependency: MEM result wins, even with WB matching too.
        id_instr(4'h2, 5'd3, 5'd1, 5'd6, 32'h5, 32'h7, 1'b0);
        cycle();
        idle();
        bus.mem_stall = 1'b1;
        bus.exm_reg_write = 1'b1; bus.exm_rd = 5'd3; bus.exm_result = 32'h10;
        #1;
        chk("fwd_mem", bus.ex_arg1, 32'h10);
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h20;
        #1;
        chk("fwd_mem_over_wb", bus.ex_arg1, 32'h10);
        cycle();

        // Register 0 never forwards.
        idle();
        id_instr(4'h3, 5'd0, 5'd2, 5'd5, 32'h0, 32'h1, 1'b0);
        cycle();
        idle();
        bus.exm_reg_write = 1'b1; bus.exm_rd = 5'd0; bus.exm_result = 32'hFF;
        #1;
        chk("r0_no_fwd", bus.ex_arg1, 32'h0);
        cycle();

        // Load-use: one stall cycle, one bubble, then the add with WB data.
        idle();
        id_instr(4'h5, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 1'b1);
        cycle();
        id_instr(4'h2, 5'd4, 5'd2, 5'd8, 32'hDEAD, 32'h3, 1'b0);
        #1;
        chk("lu_stall", 32'(bus.id_stall), 32'h1);
        cycle();
        chk("lu_bubble_valid", 32'(bus.ex_valid), 32'h0);
        chk("lu_bubble_op", 32'(bus.ex_alu_op), 32'(ADD_U));
        chk("lu_stall_clear", 32'(bus.id_stall), 32'h0);
        cycle();
        idle();
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'hABCD;
        #1;
        chk("lu_add_arg1", bus.ex_arg1, 32'hABCD);
        cycle();

        // Capture bypass on rt.
        idle();
        id_instr(4'h1, 5'd2, 5'd7, 5'd9, 32'h2, 32'h1, 1'b0);
        bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h9;
        cycle();
        idle();
        #1;
        chk("cap_bypass", bus.ex_store_data, 32'h9);
        cycle();

        // mem_stall beats flush; then flush beats a hazard.
        idle();
        id_instr(4'h5, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 1'b1);
        cycle();
        idle();
        bus.mem_stall = 1'b1; bus.flush = 1'b1;
        #1;
        chk("stall_flush_idstall", 32'(bus.id_stall), 32'h1);
        cycle();
        chk("stall_hold_valid", 32'(bus.ex_valid), 32'h1);
        chk("stall_hold_rd", 32'(bus.ex_rd), 32'h4);
        id_instr(4'h2, 5'd4, 5'd2, 5'd8, 32'h1, 32'h3, 1'b0);
        bus.mem_stall = 1'b0; bus.flush = 1'b1;
        #1;
        chk("flush_hazard_idstall", 32'(bus.id_stall), 32'h0);
        cycle();
        chk("flush_bubble", 32'(bus.ex_valid), 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle();
        end

        // Reset asserted mid-operation takes effect immediately.
        rand_inputs();
        bus.mem_stall = 1'b0;
        #2;
        rst_n = 1'b0;
        m = mk_bubble();
        args_known = 1'b1;
        #1;
        chk("rst_op", 32'(bus.ex_alu_op), 32'(ADD_U));
        chk("rst_arg1", bus.ex_arg1, 32'h0);
        check_all();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the MIPS core: registers the decoded instruction and sits directly upstream of the ALU, presenting `alu_op`, `arg1` and `arg2` to it. Operands are resolved through capture-time writeback bypass and EX-time forwarding from MEM and WB. The stage detects load-use hazards, stalling decode and inserting a bubble. It also honours branch flush and downstream (MEM) stall.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width.
- `REG_ADDR_W`, 5, register index width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_alu_op`  in  4  ALU operation, encodings per `defs.v` (`ALUOP_*`).
- `id_rs`, `id_rt`  in  REG_ADDR_W  source register indices.
- `id_rd`  in  REG_ADDR_W  destination index.
- `id_rs_val`, `id_rt_val`  in  DATA_W  register-file read data.
- `id_imm`  in  DATA_W  sign-extended immediate.
- `id_use_imm`  in  1  arg2 takes the immediate.
- `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1  control bits.
- `exm_reg_write`  in  1  MEM-stage instruction writes a register.
- `exm_rd`  in  REG_ADDR_W  MEM-stage destination index.
- `exm_result`  in  DATA_W  MEM-stage ALU result.
- `wb_reg_write`  in  1  WB-stage instruction writes a register.
- `wb_rd`  in  REG_ADDR_W  WB-stage destination index.
- `wb_data`  in  DATA_W  WB-stage write data.
- `flush`  in  1  squash the instruction entering EX.
- `mem_stall`  in  1  freeze the whole pipeline.
- `id_stall`  out  1  decode must hold its instruction.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1  registered control.
- `ex_alu_op`  out  4  to ALU `alu_op`.
- `ex_rd`  out  REG_ADDR_W  registered destination index.
- `ex_arg1`, `ex_arg2`  out  DATA_W  to ALU `arg1`/`arg2`.
- `ex_store_data`  out  DATA_W  forwarded rt value for stores.

## Operation
- Internal EX register holds: valid, op, rs, rt, rd, rs_val, rt_val, imm, use_imm and the three control bits.
- Capture bypass: when `wb_reg_write` is set, `wb_rd != 0` and `wb_rd` equals `id_rs` (or `id_rt`), capture `wb_data` in place of the register-file value.
- EX forwarding, per operand with stored index r: if r == 0, use the stored value. Otherwise forward `exm_result` when `exm_reg_write` and `exm_rd == r`. Else forward `wb_data` when `wb_reg_write` and `wb_rd == r`. Else use the stored value. MEM has priority over WB.
- Operand mapping: `ex_arg1` = fwd(rs). `ex_arg2` = `use_imm` ? imm : fwd(rt). `ex_store_data` = fwd(rt) always.
- Load-use hazard: `ex_valid & ex_mem_read & ex_rd != 0 & id_valid & (ex_rd == id_rs | (ex_rd == id_rt & ~id_use_imm))`.
- Bubble: valid, reg_write, mem_read, mem_write and rd all 0; op = `ALUOP_ADD_U`, so the ALU never sees an unknown op.
- Next-state priority, highest first:
  - `mem_stall`: hold all EX state; `flush` is ignored.
  - `flush`: load a bubble.
  - Load-use hazard: load a bubble.
  - Otherwise: capture decode; if `id_valid` = 0, load a bubble.
- `id_stall` = `mem_stall | (hazard & ~flush)`.

## Timing
- Reset (asynchronous, immediate): `ex_valid`/`ex_reg_write`/`ex_mem_read`/`ex_mem_write` = 0, `ex_rd` = 0, `ex_alu_op` = `ALUOP_ADD_U`, stored data = 0, so `ex_arg1`/`ex_arg2`/`ex_store_data` = 0 provided no forward matches (r = 0 never matches).
- Latency: decode values appear on `ex_*` one clock after capture.
- Combinational outputs: `ex_arg1`, `ex_arg2` and `ex_store_data` follow `exm_*`/`wb_*` within the same cycle. `id_stall` follows `id_*` within the same cycle.
- Load-use costs exactly one bubble: the next cycle the load sits in MEM, `ex_mem_read` = 0, and the hazard clears.
- `mem_stall` freezes WB as well, so forwarded values remain stable during a hold.
- Reset deasserted mid-stream: first capture on the first rising edge with `rst_n` = 1.

## Test plan
- Reset asserted mid-operation -> all outputs at reset values immediately; `ex_alu_op` = `ALUOP_ADD_U`.
- Back-to-back dependency: add r3 (`exm_rd`=3, `exm_result`=0x10) followed by EX instr with rs=3, stored value 0x5 -> `ex_arg1` = 0x10. Same with `wb_rd`=3, `wb_data`=0x20 also matching -> still 0x10.
- Register 0: `exm_rd`=0, `exm_reg_write`=1, `exm_result`=0xFF, rs=0, stored 0 -> `ex_arg1` = 0.
- Load-use: EX holds lw r4; ID holds add rs=4 -> `id_stall`=1 for one cycle, then a bubble (`ex_valid`=0, op `ALUOP_ADD_U`), then add captured and `ex_arg1` = `wb_data`.
- Capture bypass: `id_rt`=7, `id_rt_val`=1, `wb_rd`=7, `wb_data`=9, `wb_reg_write`=1 -> next cycle, with no forwards, `ex_store_data` = 9.
- Stall vs flush: `mem_stall`=1 with `flush`=1 -> EX state unchanged, `id_stall`=1. Then `mem_stall`=0 with `flush`=1 and a hazard present -> bubble loaded, `id_stall`=0.
